// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy quarter/dime/nickel payout from a loadable inventory,
// one coin pulse per PULSE state with GAP idle cycles between coins.
module change_dispenser #(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [5:0] amount,
  input  logic       stock_load,
  input  logic [7:0] load_nickel,
  input  logic [7:0] load_dime,
  input  logic [7:0] load_quarter,
  output logic       busy,
  output logic       nickel_out,
  output logic       dime_out,
  output logic       quarter_out,
  output logic       done,
  output logic [5:0] shortfall,
  output logic [7:0] stock_nickel,
  output logic [7:0] stock_dime,
  output logic [7:0] stock_quarter,
  output logic       nickel_empty,
  output logic       dime_empty,
  output logic       quarter_empty
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [5:0] rem_q, rem_d;
  logic [7:0] stk_n_q, stk_n_d, stk_d_q, stk_d_d, stk_q_q, stk_q_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [5:0] shortfall_q, shortfall_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       n_out_q, n_out_d, d_out_q, d_out_d, q_out_q, q_out_d;
  logic       pick_q, pick_d, pick_n;

  // Greedy choice; the guards also keep remaining and every stock from underflowing.
  always_comb begin
    pick_q = (rem_q >= 6'd5) && (stk_q_q != 8'd0);
    pick_d = !pick_q && (rem_q >= 6'd2) && (stk_d_q != 8'd0);
    pick_n = !pick_q && !pick_d && (rem_q >= 6'd1) && (stk_n_q != 8'd0);
  end

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      stk_n_q     <= '0;
      stk_d_q     <= '0;
      stk_q_q     <= '0;
      gap_cnt_q   <= '0;
      shortfall_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      n_out_q     <= 1'b0;
      d_out_q     <= 1'b0;
      q_out_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stk_n_q     <= stk_n_d;
      stk_d_q     <= stk_d_d;
      stk_q_q     <= stk_q_d;
      gap_cnt_q   <= gap_cnt_d;
      shortfall_q <= shortfall_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      n_out_q     <= n_out_d;
      d_out_q     <= d_out_d;
      q_out_q     <= q_out_d;
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    stk_n_d   = stk_n_q;
    stk_d_d   = stk_d_q;
    stk_q_d   = stk_q_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (stock_load) begin
          stk_n_d = load_nickel;
          stk_d_d = load_dime;
          stk_q_d = load_quarter;
        end
        if (req) begin
          rem_d   = amount;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        state_d = S_PULSE;
        if (pick_q) begin
          rem_d   = rem_q - 6'd5;
          stk_q_d = stk_q_q - 8'd1;
        end else if (pick_d) begin
          rem_d   = rem_q - 6'd2;
          stk_d_d = stk_d_q - 8'd1;
        end else if (pick_n) begin
          rem_d   = rem_q - 6'd1;
          stk_n_d = stk_n_q - 8'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PULSE: begin
        gap_cnt_d = GAP_LOAD;
        state_d   = (GAP == 0) ? S_SELECT : S_GAP;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q == 4'd0) state_d = S_SELECT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    q_out_d     = (state_q == S_SELECT) && pick_q;
    d_out_d     = (state_q == S_SELECT) && pick_d;
    n_out_d     = (state_q == S_SELECT) && pick_n;
    shortfall_d = (state_d == S_DONE) ? rem_q : shortfall_q;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign nickel_out    = n_out_q;
  assign dime_out      = d_out_q;
  assign quarter_out   = q_out_q;
  assign shortfall     = shortfall_q;
  assign stock_nickel  = stk_n_q;
  assign stock_dime    = stk_d_q;
  assign stock_quarter = stk_q_q;
  assign nickel_empty  = (stk_n_q == 8'd0);
  assign dime_empty    = (stk_d_q == 8'd0);
  assign quarter_empty = (stk_q_q == 8'd0);

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: GAP, 1, idle cycles inserted after each coin pulse (0..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 Port: req  input  1  payout request, sampled only while busy is low.
REQ-005 Port: amount  input  6  change to pay, in nickel units (0..63), sampled with req.
REQ-006 Port: stock_load  input  1  load coin inventory, honoured only while busy is low.
REQ-007 Port: load_nickel / load_dime / load_quarter  input  8 each  inventory values written on stock_load.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: nickel_out / dime_out / quarter_out  output  1 each  one-cycle pulse per coin ejected.
REQ-010 Port: done  output  1  one-cycle pulse at end of a payout.
REQ-011 Port: shortfall  output  6  unpaid remainder in nickel units, valid from done, held until next done.
REQ-012 Port: stock_nickel / stock_dime / stock_quarter  output  8 each  current inventory.
REQ-013 Port: nickel_empty / dime_empty / quarter_empty  output  1 each  high when matching stock is 0.

Function
REQ-014 FSM states: IDLE, SELECT, PULSE, GAP, DONE; outputs registered.
REQ-015 IDLE: req high at edge N -> latch amount into 6-bit remaining, state SELECT in cycle N+1.
REQ-016 IDLE, req low: stay IDLE; req while busy high ignored, no queueing.
REQ-017 stock_load high while busy low: all three stocks take load values at that edge; ignored while busy high.
REQ-018 stock_load and req at same IDLE edge: both honoured; first SELECT uses loaded stock.
REQ-019 SELECT greedy priority: remaining>=5 and stock_quarter>0 -> quarter; else remaining>=2 and stock_dime>0 -> dime; else remaining>=1 and stock_nickel>0 -> nickel; else -> DONE.
REQ-020 Coin chosen -> PULSE next cycle: exactly one coin output high for that one cycle; at same edge remaining decrements by 5/2/1 and matching stock by 1.
REQ-021 PULSE -> GAP for GAP cycles, then SELECT; GAP=0 -> PULSE goes directly to SELECT.
REQ-022 Pulse spacing: consecutive coin pulses exactly GAP+2 cycles apart; first pulse in cycle N+2.
REQ-023 At most one coin output high in any cycle; coin outputs never high outside PULSE.
REQ-024 DONE: done high for one cycle, shortfall <= remaining, next state IDLE (busy low next cycle).
REQ-025 amount=0 or no payable coin: no pulses, done in cycle N+2, shortfall = amount.
REQ-026 Stocks never underflow; never decrement below 0; no increment path other than stock_load.
REQ-027 remaining never underflows; guards in REQ-019 guarantee it.
REQ-028 Empty flags combinational from stock registers, valid every cycle.

Reset
REQ-029 rst_n low at edge: state IDLE, remaining 0, all stocks 0, shortfall 0, busy/done/coin outputs 0, empty flags 1.
REQ-030 Reset mid-payout: aborts immediately; no done; stock decrements already made persist only if not reset (reset clears stock to 0).
REQ-031 Reset priority over req and stock_load at same edge.

Verification
REQ-032 Reset: rst_n low 2 cycles -> all outputs 0, empty flags 1, stocks 0.
REQ-033 Load 10/10/10, GAP=1, req amount=8 at N -> quarter N+2, dime N+5, nickel N+8, done N+11, shortfall 0, stocks 9/9/9.
REQ-034 Load nickel=5, dime=5, quarter=0, amount=5 -> dime, dime, nickel, shortfall 0, quarter_empty stays 1.
REQ-035 Load nickel=1, others 0, amount=3 -> one nickel_out, done, shortfall 2, nickel_empty 1.
REQ-036 amount=0 -> no coin pulses, done at N+2; second req during busy of a later payout -> ignored, single done.
REQ-037 rst_n low between first and second pulse of amount=8 payout -> no further pulses, no done, busy 0 next cycle.
